// File: rtl/mod241_residue_accum.sv
// rtl/mod241_residue_accum.sv - streaming mod-241 accumulator of 6-bit-slice partial residues
// Optional beat-count integrity check: define MOD241_ACC_CNTCHK_EN to enable out_err.
module mod241_residue_accum #(
  parameter int MOD      = 241,
  parameter int W        = 8,
  parameter int N_CHUNKS = 84,
  parameter int CW       = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_res,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_res,
  output logic         out_err
);

  // Reject parameter sets where the modulus or the counter cannot be represented.
  if ((2 ** CW) <= N_CHUNKS || MOD < 2 || MOD > (2 ** W) - 1) begin : g_bad_cfg
    $error("mod241_residue_accum: illegal MOD/W/N_CHUNKS/CW combination");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [W:0]    MOD_X   = (W+1)'(MOD);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        r_state;
  state_t        w_next_state;
  logic [W-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_out_res;

  logic          w_accept;
  logic          w_out_hs;
  logic [W-1:0]  w_acc_base;
  logic [W:0]    w_sum;
  logic [W:0]    w_s1;
  logic [W-1:0]  w_red;
  logic [CW-1:0] w_cnt_base;
  logic [CW-1:0] w_cnt_inc;

  assign w_accept = in_valid && in_ready;
  assign w_out_hs = out_valid && out_ready;

  // IDLE always starts a fresh operand from zero, independent of leftover acc/cnt.
  assign w_acc_base = (r_state == S_IDLE) ? '0 : r_acc;
  assign w_cnt_base = (r_state == S_IDLE) ? '0 : r_cnt;

  // The sum is kept at W+1 bits; in_res may exceed MOD, so up to two subtracts are needed.
  assign w_sum = {1'b0, w_acc_base} + {1'b0, in_res};
  assign w_s1  = (w_sum >= MOD_X) ? (w_sum - MOD_X) : w_sum;
  assign w_red = (w_s1 >= MOD_X) ? W'(w_s1 - MOD_X) : w_s1[W-1:0];

  // Counter saturates rather than wrapping so an over-long operand cannot alias a good count.
  assign w_cnt_inc = (w_cnt_base == CNT_MAX) ? CNT_MAX : (w_cnt_base + CW'(1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = in_last ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_accept && in_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state so reset is visible immediately.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    if (r_state == S_DONE) begin
      in_ready  = 1'b0;
      out_valid = 1'b1;
    end
  end

  // Running residue and beat count; both return to zero once the result is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= w_red;
      r_cnt <= w_cnt_inc;
    end else if (w_out_hs) begin
      r_acc <= '0;
      r_cnt <= '0;
    end
  end

  // Result register, loaded on the final beat and held through the output stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_res <= '0;
    end else if (w_accept && in_last) begin
      r_out_res <= w_red;
    end
  end

  assign out_res = r_out_res;

`ifdef MOD241_ACC_CNTCHK_EN
  logic r_out_err;

  // Flag operands whose beat count (including the last beat) differs from N_CHUNKS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_err <= 1'b0;
    end else if (w_accept && in_last) begin
      r_out_err <= (w_cnt_inc != CW'(N_CHUNKS));
    end else if (w_out_hs) begin
      r_out_err <= 1'b0;
    end
  end

  assign out_err = r_out_err;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_mod241_residue_accum.sv
// tb/tb_mod241_residue_accum.sv - directed scoreboard bench for mod241_residue_accum
module tb_mod241_residue_accum;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_res;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_res;
  logic       out_err;

  int total;
  int bad;
  int beats[$];
  logic [8:0] exp_q[$];

  mod241_residue_accum dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_res    (in_res),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_err   (out_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive the beats in 'beats' back to back (optional bubble before index bubble_at);
  // when do_last is set the final beat carries in_last and the expectation is queued.
  task automatic send(input int bubble_at, input bit do_last);
    int acc;
    int n;
    bit e;
    acc = 0;
    n = beats.size();
    for (int i = 0; i < n; i++) begin
      if (i == bubble_at) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bubble_ready", int'(in_ready), 1);
      end
      chk("beat_ready", int'(in_ready), 1);
      in_valid = 1'b1;
      in_res   = 8'(beats[i]);
      in_last  = do_last && (i == n - 1);
      acc = (acc + beats[i]) % 241;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
`ifdef MOD241_ACC_CNTCHK_EN
    e = (n != 84);
`else
    e = 1'b0;
`endif
    if (do_last) exp_q.push_back({e, 8'(acc)});
  endtask

  // Called the cycle after the last beat: result must already be presented.
  task automatic take(input string tag);
    logic [8:0] ex;
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_inready_lo"}, int'(in_ready), 0);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      ex = exp_q.pop_front();
      chk({tag, "_res"}, int'(out_res), int'(ex[7:0]));
      chk({tag, "_err"}, int'(out_err), int'(ex[8]));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_lo"}, int'(out_valid), 0);
    chk({tag, "_turnaround"}, int'(in_ready), 1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_res = 8'd0;
    in_last = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_res", int'(out_res), 0);
    chk("rst_err", int'(out_err), 0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    beats = '{200, 100};
    send(-1, 1'b1);
    take("op_200_100");

    beats = '{240, 255};
    send(-1, 1'b1);
    take("op_dblsub");

    beats.delete();
    for (int i = 0; i < 84; i++) beats.push_back(240);
    send(40, 1'b1);
    take("op_84x240");

    beats.delete();
    for (int i = 0; i < 83; i++) beats.push_back(240);
    send(-1, 1'b1);
    take("op_83x240");

    // Result stalls while the upstream keeps offering a beat.
    beats = '{200, 100};
    send(-1, 1'b1);
    chk("stall_res_first", int'(out_res), 59);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_res   = 8'd7;
      in_last  = 1'b0;
      @(posedge clk); #1;
      chk("stall_ready", int'(in_ready), 0);
      chk("stall_res", int'(out_res), 59);
    end
    in_valid = 1'b0;
    take("op_stall");
    beats = '{7};
    send(-1, 1'b1);
    take("op_single7");

    // Asynchronous reset in the middle of a cycle during accumulation.
    beats.delete();
    for (int i = 0; i < 10; i++) beats.push_back(50 + i);
    send(-1, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("arst_ready", int'(in_ready), 1);
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_res", int'(out_res), 0);
    chk("arst_err", int'(out_err), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    beats = '{1};
    send(-1, 1'b1);
    take("op_after_rst");

    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod241_residue_accum.md
# mod241_residue_accum

Sequential reduction stage that sits directly downstream of the 6-bit-slice residue LUTs for the mod-241 datapath. Each LUT maps one 6-bit slice of the 500-bit operand to an 8-bit partial residue. This block consumes those partial residues one per beat over a valid/ready stream. It accumulates them modulo 241 and emits the final 8-bit residue of the whole operand, with a chunk-count integrity flag.

## Interface
Parameters:
- MOD, 241, modulus; must satisfy 2 ≤ MOD ≤ 2^W − 1
- W, 8, residue width in bits
- N_CHUNKS, 84, beats per operand (ceil(500/6))
- CW, 7, chunk-counter width; must satisfy 2^CW > N_CHUNKS

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  partial residue present
- in_ready  out  1  block accepts a beat
- in_res  in  W  partial residue; any value 0..2^W−1 is legal
- in_last  in  1  final beat of the operand
- out_valid  out  1  final residue present
- out_ready  in  1  consumer accepts the result
- out_res  out  W  final residue, always in 0..MOD−1
- out_err  out  1  beat-count mismatch for this operand (see Configuration)

## Operation
- Reset state: IDLE. Reset values: acc=0, cnt=0, in_ready=1, out_valid=0, out_res=0, out_err=0.
- The reset is asynchronous and takes effect mid-operation. Any partial accumulation and any pending result are discarded.
- A beat is accepted when in_valid && in_ready.
- States:
  - IDLE: in_ready=1. An accepted beat computes acc=red(0+in_res) and cnt=1. If in_last, go to DONE; otherwise go to ACCUM.
  - ACCUM: in_ready=1. An accepted beat computes acc=red(acc+in_res) and cnt=cnt+1. If in_last, go to DONE.
  - DONE: in_ready=0 and out_valid=1. out_res and out_err hold stable until out_ready. On out_valid && out_ready, go to IDLE with acc=0 and cnt=0.
- Reduction red(s), where s is W+1 bits and s ≤ (MOD−1)+(2^W−1):
  - s1 = s≥MOD ? s−MOD : s
  - result = s1≥MOD ? s1−MOD : s1
  - Two conditional subtracts are mandatory because in_res is not guaranteed to be below MOD. The sum must not be truncated to W bits before reduction.
- out_res is registered: it is loaded with the reduced value on the in_last beat.
- Counter: cnt saturates at 2^CW−1 and never wraps.
- in_valid=0 in ACCUM leaves the state unchanged (bubbles allowed).
- Inputs sampled while in_ready=0 are ignored. in_res and in_last are don't-care when in_valid=0.

## Timing
- Throughput: one beat per cycle in IDLE/ACCUM.
- Latency: out_valid rises on the clock edge that accepts the in_last beat, i.e. it is visible the next cycle.
- Turnaround: the cycle after the output handshake, in_ready=1 (IDLE). There is one dead input cycle per operand: no input is accepted during the handshake cycle itself.
- Single-beat operand (in_last on the first beat) is legal: IDLE goes straight to DONE.
- The reduction is combinational within one cycle. There is no internal pipeline.

## Configuration
- MOD241_ACC_CNTCHK_EN defined:
  - On the in_last beat, out_err is registered as (cnt+1 ≠ N_CHUNKS), using the saturated count.
  - out_err is valid with out_valid and is cleared on the output handshake.
- Not defined:
  - Count comparison logic is removed and out_err is tied to 0.
  - cnt still exists, but only for state bookkeeping: it may be optimised away.

## Test plan
- Beats 200, 100 (last) -> out_valid the next cycle, out_res=59. out_err=1 if the macro is defined, else 0.
- Beats 240, 255 (last), exercising the double subtract -> out_res=13.
- 84 beats of 240, last on the 84th -> out_res=157, out_err=0.
- 83 beats of 240, last on the 83rd:
  - out_res=(−83 mod 241)=158
  - out_err=1 with MOD241_ACC_CNTCHK_EN, 0 without
- Result pending with out_ready held low 5 cycles while in_valid=1 and in_res=7:
  - in_ready=0 and out_res stable for all 5 cycles; no beat is absorbed.
  - After the handshake, the next operand of a single beat 7 (last) -> out_res=7.
- rst pulsed asynchronously mid-clock after 10 accepted beats:
  - Outputs immediately read in_ready=1, out_valid=0, out_res=0.
  - Next operand of beat 1 (last) -> out_res=1.
